// File: rtl/fc_fixed_pkg.sv
// rtl/fc_fixed_pkg.sv - Q5.11 fixed-point constants and sequencer state type for the FC neuron MAC
package fc_fixed_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 11;
  localparam int ACC_W  = 28;
  localparam int LEN_W  = 10;

  localparam logic [DATA_W-1:0] Q_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] Q_MIN = 16'h8000;

  localparam int INT_MAX = 15;
  localparam int INT_MIN = -16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

endpackage

// File: rtl/fc_mac_sequencer_if.sv
// rtl/fc_mac_sequencer_if.sv - job control, operand stream and result stream of the FC neuron MAC
interface fc_mac_sequencer_if;
  import fc_fixed_pkg::*;

  logic              start;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] bias;

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_x;
  logic [DATA_W-1:0] s_w;

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_sat;

  logic              busy;

  modport master (
    output start, len, bias, s_valid, s_x, s_w, m_ready,
    input  s_ready, m_valid, m_data, m_sat, busy
  );

  modport slave (
    input  start, len, bias, s_valid, s_x, s_w, m_ready,
    output s_ready, m_valid, m_data, m_sat, busy
  );

endinterface

// File: rtl/q_product_saturate.sv
// rtl/q_product_saturate.sv - clips a Q10.22 product to Q5.11, truncating toward -inf
module q_product_saturate
  import fc_fixed_pkg::*;
(
  input  logic signed [2*DATA_W-1:0] prod,
  output logic        [DATA_W-1:0]   q,
  output logic                       sat
);

  localparam int IP_W = 2*(DATA_W-FRAC_W);
  localparam logic signed [IP_W-1:0] IP_HI = IP_W'(INT_MAX);
  localparam logic signed [IP_W-1:0] IP_LO = IP_W'(INT_MIN);

  logic signed [IP_W-1:0] ip;
  logic                   unused_lsbs;

  assign ip          = prod[2*DATA_W-1:2*FRAC_W];
  assign unused_lsbs = ^prod[FRAC_W-1:0];

  always_comb begin
    q   = prod[DATA_W+FRAC_W-1:FRAC_W];
    sat = 1'b0;
    if (ip > IP_HI) begin
      q   = Q_MAX;
      sat = 1'b1;
    end else if (ip < IP_LO) begin
      q   = Q_MIN;
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/fc_mac_sequencer.sv
// rtl/fc_mac_sequencer.sv - one FC neuron: bias + sum of clipped x*w products, clipped to Q5.11
module fc_mac_sequencer
  import fc_fixed_pkg::*;
(
  input logic               clk,
  input logic               rst,
  fc_mac_sequencer_if.slave bus
);

  localparam logic signed [ACC_W-1:0] ACC_HI = {{(ACC_W-DATA_W){1'b0}}, Q_MAX};
  localparam logic signed [ACC_W-1:0] ACC_LO = {{(ACC_W-DATA_W){1'b1}}, Q_MIN};

  state_t                    state;
  logic [LEN_W-1:0]          len_q;
  logic [LEN_W-1:0]          cnt;
  logic                      flush_cnt;
  logic signed [ACC_W-1:0]   acc;
  logic signed [2*DATA_W-1:0] prod;
  logic                      prod_vld;

  logic [DATA_W-1:0]         prod_q;
  logic                      prod_sat;
  logic signed [2*DATA_W-1:0] sx;
  logic signed [2*DATA_W-1:0] sw;
  logic                      hs;
  logic [DATA_W-1:0]         fin_q;
  logic                      fin_sat;

  q_product_saturate u_qsat (
    .prod (prod),
    .q    (prod_q),
    .sat  (prod_sat)
  );

  assign bus.s_ready = (state == RUN);
  assign bus.busy    = (state != IDLE);
  assign hs          = bus.s_valid && (state == RUN);

  assign sx = {{DATA_W{bus.s_x[DATA_W-1]}}, bus.s_x};
  assign sw = {{DATA_W{bus.s_w[DATA_W-1]}}, bus.s_w};

  always_comb begin
    fin_q   = acc[DATA_W-1:0];
    fin_sat = 1'b0;
    if (acc > ACC_HI) begin
      fin_q   = Q_MAX;
      fin_sat = 1'b1;
    end else if (acc < ACC_LO) begin
      fin_q   = Q_MIN;
      fin_sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      len_q       <= '0;
      cnt         <= '0;
      flush_cnt   <= 1'b0;
      acc         <= '0;
      prod        <= '0;
      prod_vld    <= 1'b0;
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      bus.m_sat   <= 1'b0;
    end else begin
      prod_vld <= 1'b0;

      // The product register lags the handshake by one edge, so the last
      // product is folded in on the first FLUSH edge.
      if (prod_vld) begin
        acc <= acc + {{(ACC_W-DATA_W){prod_q[DATA_W-1]}}, prod_q};
        if (prod_sat) begin
          bus.m_sat <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (bus.start && (bus.len != '0)) begin
            state     <= RUN;
            len_q     <= bus.len;
            acc       <= {{(ACC_W-DATA_W){bus.bias[DATA_W-1]}}, bus.bias};
            cnt       <= '0;
            bus.m_sat <= 1'b0;
          end
        end
        RUN: begin
          if (hs) begin
            prod     <= sx * sw;
            prod_vld <= 1'b1;
            cnt      <= cnt + LEN_W'(1);
            if (cnt == len_q - LEN_W'(1)) begin
              state     <= FLUSH;
              flush_cnt <= 1'b0;
            end
          end
        end
        FLUSH: begin
          flush_cnt <= 1'b1;
          if (flush_cnt) begin
            bus.m_data  <= fin_q;
            bus.m_valid <= 1'b1;
            if (fin_sat) begin
              bus.m_sat <= 1'b1;
            end
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.m_valid && bus.m_ready) begin
            bus.m_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_mac_sequencer.sv
// tb/tb_fc_mac_sequencer.sv - table-driven and scoreboard checks of the FC neuron MAC sequencer
module tb_fc_mac_sequencer;
  import fc_fixed_pkg::*;

  typedef struct {
    int          len;
    logic [15:0] bias;
    logic [15:0] x;
    logic [15:0] w;
    logic [15:0] exp_data;
    logic        exp_sat;
    logic        gaps;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        sat;
  } exp_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  vec_t vt[7];
  exp_t sb[$];

  fc_mac_sequencer_if ifc();

  fc_mac_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic run_job(input int n, input logic [15:0] b, input logic [15:0] x,
                         input logic [15:0] w, input logic gaps,
                         output int hs_cnt, output int lat);
    int guard;
    ifc.start = 1'b1;
    ifc.len   = n[LEN_W-1:0];
    ifc.bias  = b;
    step();
    ifc.start = 1'b0;
    hs_cnt = 0;
    guard  = 0;
    while (hs_cnt < n && guard < 500) begin
      ifc.s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      ifc.s_x = x;
      ifc.s_w = w;
      if (ifc.s_valid && ifc.s_ready) hs_cnt++;
      step();
      guard++;
    end
    // Keep offering pairs during FLUSH; none may be consumed.
    ifc.s_valid = 1'b1;
    chk("s_ready_low_after_last", ifc.s_ready, 1'b0);
    lat = 0;
    while (!ifc.m_valid && lat < 20) begin
      step();
      lat++;
    end
    ifc.s_valid = 1'b0;
  endtask

  task automatic take_result(input int hold, input logic poke);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      $display("FAIL scoreboard_empty: got no expected entry, required one");
      return;
    end
    e = sb.pop_front();
    ifc.m_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      ifc.start = poke && (i == 1 || i == 3);
      ifc.len   = (i == 1) ? 10'd3 : 10'd0;
      step();
      chk("hold_m_valid", ifc.m_valid, 1'b1);
      chk("hold_m_data", ifc.m_data, e.data);
      chk("hold_busy", ifc.busy, 1'b1);
    end
    ifc.start = 1'b0;
    chk("m_data", ifc.m_data, e.data);
    chk("m_sat", ifc.m_sat, e.sat);
    ifc.m_ready = 1'b1;
    ifc.start   = poke;
    ifc.len     = 10'd2;
    step();
    ifc.m_ready = 1'b0;
    ifc.start   = 1'b0;
    chk("m_valid_drop", ifc.m_valid, 1'b0);
    chk("idle_after_accept", ifc.busy, 1'b0);
    chk("m_data_kept", ifc.m_data, e.data);
  endtask

  initial begin
    int hs_cnt;
    int lat;
    exp_t e;

    vt[0] = '{len:1, bias:16'h0000, x:16'h0800, w:16'h1000, exp_data:16'h1000, exp_sat:1'b0, gaps:1'b0};
    vt[1] = '{len:4, bias:16'h0400, x:16'h0800, w:16'h0400, exp_data:16'h1400, exp_sat:1'b0, gaps:1'b1};
    vt[2] = '{len:1, bias:16'h0000, x:16'h7FFF, w:16'h7FFF, exp_data:16'h7FFF, exp_sat:1'b1, gaps:1'b0};
    vt[3] = '{len:1, bias:16'h0000, x:16'h8000, w:16'h7FFF, exp_data:16'h8000, exp_sat:1'b1, gaps:1'b0};
    vt[4] = '{len:3, bias:16'h0000, x:16'h1800, w:16'h2000, exp_data:16'h7FFF, exp_sat:1'b1, gaps:1'b0};
    vt[5] = '{len:2, bias:16'hF000, x:16'h0800, w:16'hF800, exp_data:16'hE000, exp_sat:1'b0, gaps:1'b1};
    vt[6] = '{len:2, bias:16'h8000, x:16'h8000, w:16'h0800, exp_data:16'h8000, exp_sat:1'b1, gaps:1'b0};

    rst = 1'b1;
    ifc.start = 1'b0;
    ifc.len = '0;
    ifc.bias = '0;
    ifc.s_valid = 1'b0;
    ifc.s_x = '0;
    ifc.s_w = '0;
    ifc.m_ready = 1'b0;
    repeat (3) step();
    chk("rst_s_ready", ifc.s_ready, 1'b0);
    chk("rst_m_valid", ifc.m_valid, 1'b0);
    chk("rst_m_sat", ifc.m_sat, 1'b0);
    chk("rst_busy", ifc.busy, 1'b0);
    chk("rst_m_data", ifc.m_data, 16'h0000);
    rst = 1'b0;
    step();

    for (int r = 0; r < 7; r++) begin
      e.data = vt[r].exp_data;
      e.sat  = vt[r].exp_sat;
      sb.push_back(e);
      run_job(vt[r].len, vt[r].bias, vt[r].x, vt[r].w, vt[r].gaps, hs_cnt, lat);
      chk("handshakes", hs_cnt, vt[r].len);
      chk("latency_edges", lat, 2);
      take_result((r == 1) ? 2 : 0, 1'b0);
      step();
    end

    // Result held under backpressure; start pulses in DONE and on the exit cycle ignored.
    e.data = 16'h1000;
    e.sat  = 1'b0;
    sb.push_back(e);
    run_job(2, 16'h0000, 16'h0800, 16'h0800, 1'b0, hs_cnt, lat);
    chk("bp_latency_edges", lat, 2);
    take_result(5, 1'b1);
    step();
    chk("exit_start_ignored", ifc.busy, 1'b0);
    chk("exit_start_no_ready", ifc.s_ready, 1'b0);

    ifc.start = 1'b1;
    ifc.len   = 10'd0;
    step();
    ifc.start = 1'b0;
    chk("len0_ignored_busy", ifc.busy, 1'b0);
    chk("len0_ignored_ready", ifc.s_ready, 1'b0);

    // Reset after two of four pairs discards the job.
    ifc.start = 1'b1;
    ifc.len   = 10'd4;
    ifc.bias  = 16'h0400;
    step();
    ifc.start   = 1'b0;
    ifc.s_valid = 1'b1;
    ifc.s_x     = 16'h0800;
    ifc.s_w     = 16'h0800;
    repeat (2) step();
    chk("mid_job_busy", ifc.busy, 1'b1);
    ifc.s_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", ifc.busy, 1'b0);
    chk("mid_rst_s_ready", ifc.s_ready, 1'b0);
    chk("mid_rst_m_valid", ifc.m_valid, 1'b0);
    chk("mid_rst_m_sat", ifc.m_sat, 1'b0);
    chk("mid_rst_m_data", ifc.m_data, 16'h0000);
    repeat (4) step();
    chk("mid_rst_no_output", ifc.m_valid, 1'b0);

    e.data = 16'h0800;
    e.sat  = 1'b0;
    sb.push_back(e);
    run_job(1, 16'h0000, 16'h0800, 16'h0800, 1'b0, hs_cnt, lat);
    chk("post_rst_latency_edges", lat, 2);
    take_result(0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
